// File: rtl/bitstream_decoder_125.sv
// bitstream_decoder_125: counts ones per 125-sample window, with a base-5 radical-inverse phase and a valid/ready result.
module bitstream_decoder_125 #(
    parameter int WINDOW   = 125,
    parameter int OUTWIDTH = 7
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic                in_bit,
    input  logic                sync,
    input  logic                out_ready,
    output logic                out_valid,
    output logic [OUTWIDTH-1:0] out_data,
    output logic [OUTWIDTH-1:0] phase,
    output logic                overrun
);
    logic [2:0] d0, d1, d2;
    logic [OUTWIDTH-1:0] acc, pos, sum;
    logic accept, last;
    assign accept = in_valid & ~sync;
    assign pos = OUTWIDTH'(d0) + OUTWIDTH'(d1) * OUTWIDTH'(5) + OUTWIDTH'(d2) * OUTWIDTH'(25);
    // Digit weights reversed relative to pos: the radical inverse.
    assign phase = OUTWIDTH'(d2) + OUTWIDTH'(d1) * OUTWIDTH'(5) + OUTWIDTH'(d0) * OUTWIDTH'(25);
    assign last = accept && pos == OUTWIDTH'(WINDOW - 1);
    assign sum = acc + OUTWIDTH'(in_bit);
    always_ff @(posedge clk) begin
        if (rst) begin
            d0 <= '0;
            d1 <= '0;
            d2 <= '0;
            acc <= '0;
            out_data <= '0;
            out_valid <= 1'b0;
            overrun <= 1'b0;
        end else begin
            if (sync) begin
                d0 <= '0;
                d1 <= '0;
                d2 <= '0;
                acc <= '0;
            end else if (in_valid) begin
                d0 <= d0 == 3'd4 ? 3'd0 : d0 + 3'd1;
                if (d0 == 3'd4) d1 <= d1 == 3'd4 ? 3'd0 : d1 + 3'd1;
                if (d0 == 3'd4 && d1 == 3'd4) d2 <= d2 == 3'd4 ? 3'd0 : d2 + 3'd1;
                acc <= last ? '0 : sum;
            end
            if (last) begin
                out_data <= sum;
                out_valid <= 1'b1;
                overrun <= overrun | (out_valid & ~out_ready);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bitstream_decoder_125.sv
// tb_bitstream_decoder_125: directed scenarios plus random traffic against an integer-position reference model.
module tb_bitstream_decoder_125;
    logic clk = 1'b0;
    logic rst, in_valid, in_bit, sync, out_ready;
    logic out_valid, overrun;
    logic [6:0] out_data, phase;
    int errors = 0, checks = 0;
    int m_pos, m_acc, m_od;
    logic m_vld, m_ov;

    bitstream_decoder_125 dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit), .sync(sync),
        .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
        .phase(phase), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input logic v, input logic b, input logic s, input logic r, input logic rdy);
        bit done;
        in_valid = v; in_bit = b; sync = s; rst = r; out_ready = rdy;
        @(posedge clk);
        if (r) begin
            m_pos = 0; m_acc = 0; m_od = 0; m_vld = 0; m_ov = 0;
        end else begin
            done = v && !s && m_pos == 124;
            if (s) begin
                m_pos = 0; m_acc = 0;
            end else if (v) begin
                if (done) begin
                    m_od = m_acc + int'(b); m_pos = 0; m_acc = 0;
                end else begin
                    m_pos++; m_acc += int'(b);
                end
            end
            if (done) begin
                if (m_vld && !rdy) m_ov = 1;
                m_vld = 1;
            end else if (m_vld && rdy) m_vld = 0;
        end
        #1;
        check("out_valid", 32'(out_valid), 32'(m_vld));
        check("out_data", 32'(out_data), 32'(m_od));
        check("overrun", 32'(overrun), 32'(m_ov));
        check("phase", 32'(phase), 32'(m_pos / 25 + 5 * ((m_pos / 5) % 5) + 25 * (m_pos % 5)));
    endtask

    initial begin
        step(0, 0, 0, 1, 0);
        check("reset_valid", 32'(out_valid), 0);
        check("reset_phase", 32'(phase), 0);
        // all ones, consumer always ready
        for (int i = 0; i < 125; i++) step(1, 1, 0, 0, 1);
        check("all1_data", 32'(out_data), 125);
        check("all1_valid", 32'(out_valid), 1);
        check("all1_phase", 32'(phase), 0);
        step(0, 0, 0, 0, 1);
        check("all1_drain", 32'(out_valid), 0);
        // alternating bits with in_valid gaps every third cycle
        begin
            int n = 0, c = 0;
            while (n < 125) begin
                if (c % 3 == 2) step(0, 1, 0, 0, 1);
                else begin
                    if (n == 1) check("alt_phase1", 32'(phase), 25);
                    if (n == 5) check("alt_phase5", 32'(phase), 5);
                    step(1, n % 2 == 0, 0, 0, 1);
                    n++;
                end
                c++;
            end
        end
        check("alt_data", 32'(out_data), 63);
        // sync mid-window, sample with sync discarded
        for (int i = 0; i < 60; i++) step(1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        check("sync_phase", 32'(phase), 0);
        for (int i = 0; i < 125; i++) step(1, 0, 0, 0, 1);
        check("sync_data", 32'(out_data), 0);
        // sync on the would-be final sample
        for (int i = 0; i < 124; i++) step(1, 1, 0, 0, 1);
        step(1, 1, 1, 0, 1);
        check("sync124_valid", 32'(out_valid), 0);
        // two windows unconsumed
        for (int i = 0; i < 250; i++) step(1, i < 125, 0, 0, 0);
        check("ovr_data", 32'(out_data), 0);
        check("ovr_valid", 32'(out_valid), 1);
        check("ovr_flag", 32'(overrun), 1);
        step(0, 0, 0, 0, 1);
        check("ovr_drain", 32'(out_valid), 0);
        check("ovr_sticky", 32'(overrun), 1);
        // reset mid-window
        for (int i = 0; i < 70; i++) step(1, 1, 0, 0, 1);
        step(1, 1, 1, 1, 1);
        check("rst_ovr", 32'(overrun), 0);
        check("rst_phase", 32'(phase), 0);
        for (int i = 0; i < 124; i++) step(1, 1, 0, 0, 1);
        check("rst_early", 32'(out_valid), 0);
        step(1, 1, 0, 0, 1);
        check("rst_data", 32'(out_data), 125);
        // random traffic
        for (int i = 0; i < 4000; i++)
            step($urandom_range(3) != 0, $urandom_range(1), $urandom_range(63) == 0,
                 $urandom_range(999) == 0, $urandom_range(2) != 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/bitstream_decoder_125.md
BITSTREAM_DECODER_125 -- requirements
Module: bitstream_decoder_125

Interface
REQ-001 SHALL have parameter WINDOW, default 125, meaning the samples per decode window; fixed as three cascaded mod-5 digits (5^3).
REQ-002 SHALL have parameter OUTWIDTH, default 7, meaning the width of the decoded count and the phase output.
REQ-003 clk  input  1  clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 in_valid  input  1  in_bit carries a sample this cycle.
REQ-006 in_bit  input  1  unary bitstream sample.
REQ-007 sync  input  1  window realign request.
REQ-008 out_ready  input  1  consumer accepts out_data this cycle.
REQ-009 out_valid  output  1  decoded window count available.
REQ-010 out_data  output  OUTWIDTH  number of ones in the last completed window, 0..125.
REQ-011 phase  output  OUTWIDTH  base-5 radical inverse of the current window position.
REQ-012 overrun  output  1  sticky flag: a completed result was lost.

Function
REQ-013 Window position SHALL be three mod-5 digits d0 (LSD), d1, d2; d0 increments on each accepted sample (in_valid=1, sync=0); d(i+1) increments when d(i)=4 and d(i) is carrying.
REQ-014 Position SHALL range 0..124 and wrap to 0 (all digits 0) after the sample accepted at position 124.
REQ-015 phase SHALL equal d2 + 5*d1 + 25*d0 from registered digits, combinational with no extra cycle; it matches the sequence-generator output value for the same position.
REQ-016 Accumulator acc (OUTWIDTH bits) SHALL add in_bit on each accepted sample at positions 0..123.
REQ-017 On the sample accepted at position 124: out_data SHALL load acc+in_bit, acc SHALL clear to 0, and out_valid SHALL be set, all at the same edge (latency: 1 cycle after the final sample).
REQ-018 acc+in_bit SHALL never exceed 125; no saturation logic is required.
REQ-019 Cycles with in_valid=0 SHALL leave digits and acc unchanged.
REQ-020 out_valid/out_ready SHALL follow valid/ready rules: out_valid stays 1 and out_data stays stable until a cycle with out_ready=1, after which out_valid clears at the next edge.
REQ-021 When a window completes in the same cycle that out_valid=1 and out_ready=1: out_data SHALL load the new result, out_valid SHALL stay 1, and overrun SHALL be unchanged.
REQ-022 When a window completes while out_valid=1 and out_ready=0: out_data SHALL be overwritten with the new result, out_valid SHALL stay 1, and overrun SHALL set.
REQ-023 overrun SHALL remain 1 until rst.
REQ-024 sync=1 SHALL clear digits and acc at the next edge.
REQ-025 Any sample presented with sync=1 SHALL be discarded.
REQ-026 sync SHALL leave out_valid, out_data and overrun untouched.
REQ-027 sync=1 coinciding with a position-124 sample SHALL produce no result.

Reset
REQ-028 rst=1 SHALL, at the next edge, clear digits, acc, out_data, out_valid and overrun to 0, so that phase=0.
REQ-029 rst SHALL take priority over sync, in_valid and out_ready.
REQ-030 rst asserted mid-window SHALL discard the partial window.

Verification
REQ-031 125 accepted samples all 1, out_ready=1 -> out_valid pulses one cycle after the 125th sample with out_data=125; phase returns to 0.
REQ-032 Alternating 1,0 starting with 1 over 125 samples, with in_valid deasserted every third cycle -> out_data=63; phase sequence 0,25,50,75,100,5,30,...
REQ-033 60 ones, sync=1, then 125 zeros -> out_data=0; no result emitted at the pre-sync boundary.
REQ-034 out_ready=0, two full windows of all 1s then all 0s -> out_data=0, out_valid=1, overrun=1; out_ready=1 one cycle -> out_valid=0, overrun still 1.
REQ-035 rst=1 for one cycle at position 70, then 125 ones -> all outputs 0 after reset; result 125 emitted only after a full fresh window.
